// File: rtl/monitor_fx_pkg.sv
// monitor_fx_pkg: mode codes, luma weights, mode count and channel widening shared by monitor_fx.
// The mode count depends on MONITOR_FX_AMBER_EN.
package monitor_fx_pkg;
  localparam logic [1:0] MODE_COLOUR = 2'd0;
  localparam logic [1:0] MODE_GREEN  = 2'd1;
  localparam logic [1:0] MODE_GREY   = 2'd2;
  localparam logic [1:0] MODE_AMBER  = 2'd3;
  localparam int LUMA_WR = 2;
  localparam int LUMA_WG = 5;
  localparam int LUMA_WB = 1;
  localparam int LUMA_SHIFT = 3;
`ifdef MONITOR_FX_AMBER_EN
  localparam int NMODES = 4;
`else
  localparam int NMODES = 3;
`endif
  // MSB-first replication of an in_w-bit value, result right-aligned in out_w bits
  function automatic logic [63:0] widen(input logic [63:0] v, input int in_w, input int out_w);
    logic [63:0] w;
    for (int i = 0; i < 64; i++) w[63-i] = v[in_w-1-(i%in_w)];
    return w >> (64 - out_w);
  endfunction
endpackage

// File: rtl/monitor_fx_mode_ctrl.sv
// monitor_fx_mode_ctrl: cycle-strobe offset counter and frame-start mode commit.
// Amber participates in the cycle only with MONITOR_FX_AMBER_EN.
module monitor_fx_mode_ctrl
  import monitor_fx_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_pix,
  input  logic       vsync_n_in,
  input  logic       mode_cycle,
  input  logic [1:0] mode_sel,
  output logic [1:0] mode_active,
  output logic [1:0] mode_next
);
  logic [1:0] offset_q, offset_d, mode_q, mode_d, requested;
  logic       cyc_q, vs_prev_q, commit;
`ifdef MONITOR_FX_AMBER_EN
  assign requested = mode_sel + offset_q;
`else
  logic [1:0] base;
  logic [2:0] sum;
  assign base      = (mode_sel == MODE_AMBER) ? MODE_COLOUR : mode_sel;
  assign sum       = {1'b0, base} + {1'b0, offset_q};
  assign requested = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
`endif
  // requested uses the pre-increment offset, so a same-clk cycle edge lands next frame
  assign commit    = ce_pix & ~vsync_n_in & vs_prev_q;
  assign mode_d    = commit ? requested : mode_q;
  assign offset_d  = (mode_cycle & ~cyc_q) ? ((offset_q == 2'(NMODES - 1)) ? 2'd0 : offset_q + 2'd1) : offset_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      offset_q  <= 2'd0;
      cyc_q     <= 1'b0;
      vs_prev_q <= 1'b1;
      mode_q    <= MODE_COLOUR;
    end else begin
      offset_q <= offset_d;
      cyc_q    <= mode_cycle;
      mode_q   <= mode_d;
      if (ce_pix) vs_prev_q <= vsync_n_in;
    end
  assign mode_active = mode_q;
  assign mode_next   = mode_d;
endmodule

// File: rtl/monitor_fx.sv
// monitor_fx: two-stage monitor emulation (colour/green/grey/amber) with delay-matched syncs.
// Amber mode is built only when MONITOR_FX_AMBER_EN is defined.
module monitor_fx
  import monitor_fx_pkg::*;
#(
  parameter int IN_W  = 3,
  parameter int OUT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce_pix,
  input  logic [IN_W-1:0]  r_in,
  input  logic [IN_W-1:0]  g_in,
  input  logic [IN_W-1:0]  b_in,
  input  logic             hsync_n_in,
  input  logic             vsync_n_in,
  input  logic             blank_in,
  input  logic [1:0]       mode_sel,
  input  logic             mode_cycle,
  output logic [OUT_W-1:0] r_out,
  output logic [OUT_W-1:0] g_out,
  output logic [OUT_W-1:0] b_out,
  output logic             hsync_n_out,
  output logic             vsync_n_out,
  output logic             blank_out,
  output logic [1:0]       mode_active
);
  localparam int LW = IN_W + 3;
  logic [IN_W-1:0]  r_s1_q, g_s1_q, b_s1_q, l_s1_q, l_d, m_r, m_g, m_b;
  logic [OUT_W-1:0] r_s2_q, g_s2_q, b_s2_q, r_d, g_d, b_d;
  logic [1:0]       m_s1_q, mode_next;
  logic             hs_s1_q, vs_s1_q, bl_s1_q, hs_s2_q, vs_s2_q, bl_s2_q;
  logic             amber, green, grey;
  monitor_fx_mode_ctrl u_ctrl (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce_pix      (ce_pix),
    .vsync_n_in  (vsync_n_in),
    .mode_cycle  (mode_cycle),
    .mode_sel    (mode_sel),
    .mode_active (mode_active),
    .mode_next   (mode_next)
  );
  assign l_d = IN_W'(LW'(LUMA_WR * r_in + LUMA_WG * g_in + LUMA_WB * b_in) >> LUMA_SHIFT);
`ifdef MONITOR_FX_AMBER_EN
  assign amber = m_s1_q == MODE_AMBER;
`else
  assign amber = 1'b0;
`endif
  assign green = m_s1_q == MODE_GREEN;
  assign grey  = m_s1_q == MODE_GREY;
  always_comb begin
    m_r = (grey | amber) ? l_s1_q : green ? l_s1_q >> 2 : r_s1_q;
    m_g = amber ? (l_s1_q >> 1) + (l_s1_q >> 3) : (grey | green) ? l_s1_q : g_s1_q;
    m_b = amber ? '0 : grey ? l_s1_q : green ? l_s1_q >> 3 : b_s1_q;
    r_d = bl_s1_q ? '0 : OUT_W'(widen(64'(m_r), IN_W, OUT_W));
    g_d = bl_s1_q ? '0 : OUT_W'(widen(64'(m_g), IN_W, OUT_W));
    b_d = bl_s1_q ? '0 : OUT_W'(widen(64'(m_b), IN_W, OUT_W));
  end
  // stage 1 captures the mode that will be live after this cycle, so the commit pixel uses the new mode
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {r_s1_q, g_s1_q, b_s1_q, l_s1_q} <= '0;
      {hs_s1_q, vs_s1_q, bl_s1_q}      <= 3'b111;
      m_s1_q                           <= MODE_COLOUR;
      {r_s2_q, g_s2_q, b_s2_q}         <= '0;
      {hs_s2_q, vs_s2_q, bl_s2_q}      <= 3'b111;
    end else if (ce_pix) begin
      {r_s1_q, g_s1_q, b_s1_q, l_s1_q} <= {r_in, g_in, b_in, l_d};
      {hs_s1_q, vs_s1_q, bl_s1_q}      <= {hsync_n_in, vsync_n_in, blank_in};
      m_s1_q                           <= mode_next;
      {r_s2_q, g_s2_q, b_s2_q}         <= {r_d, g_d, b_d};
      {hs_s2_q, vs_s2_q, bl_s2_q}      <= {hs_s1_q, vs_s1_q, bl_s1_q};
    end
  assign {r_out, g_out, b_out}              = {r_s2_q, g_s2_q, b_s2_q};
  assign {hsync_n_out, vsync_n_out, blank_out} = {hs_s2_q, vs_s2_q, bl_s2_q};
endmodule

// File: tb/tb_monitor_fx.sv
// tb_monitor_fx: directed checks of mapping, latency, mode commit, hold, blanking and reset.
module tb_monitor_fx;
`ifdef MONITOR_FX_AMBER_EN
  localparam int NM = 4;
`else
  localparam int NM = 3;
`endif
  logic       clk = 1'b0, reset_n = 1'b1, ce_pix = 1'b1;
  logic [2:0] r_in = '0, g_in = '0, b_in = '0;
  logic       hsync_n_in = 1'b1, vsync_n_in = 1'b1, blank_in = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic       mode_cycle = 1'b0;
  logic [5:0] r_out, g_out, b_out;
  logic       hsync_n_out, vsync_n_out, blank_out;
  logic [1:0] mode_active;
  int errors = 0, checks = 0;
  monitor_fx #(.IN_W(3), .OUT_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hsync_n_in(hsync_n_in), .vsync_n_in(vsync_n_in), .blank_in(blank_in),
    .mode_sel(mode_sel), .mode_cycle(mode_cycle),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hsync_n_out(hsync_n_out), .vsync_n_out(vsync_n_out), .blank_out(blank_out),
    .mode_active(mode_active)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic chk_rgb(input string tag, input int r, input int g, input int b);
    chk({tag, ".r"}, int'(r_out), r);
    chk({tag, ".g"}, int'(g_out), g);
    chk({tag, ".b"}, int'(b_out), b);
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic frame_start();
    vsync_n_in = 1'b0;
    step(1);
    vsync_n_in = 1'b1;
    step(1);
  endtask
  task automatic pulse();
    mode_cycle = 1'b1;
    step(1);
    mode_cycle = 1'b0;
    step(1);
  endtask
  initial begin
    #1 reset_n = 1'b0;
    #1;
    chk_rgb("reset", 0, 0, 0);
    chk("reset.hs", int'(hsync_n_out), 1);
    chk("reset.vs", int'(vsync_n_out), 1);
    chk("reset.bl", int'(blank_out), 1);
    chk("reset.mode", int'(mode_active), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    r_in = 3'd5; g_in = 3'd2; b_in = 3'd7; hsync_n_in = 1'b0;
    step(1);
    chk("lat1.hs", int'(hsync_n_out), 1);
    chk("lat1.bl", int'(blank_out), 1);
    step(1);
    chk("lat2.hs", int'(hsync_n_out), 0);
    chk("lat2.bl", int'(blank_out), 0);
    chk_rgb("colour", 45, 18, 63);
    hsync_n_in = 1'b1;
    mode_sel = 2'd2;
    step(1);
    chk("grey.midframe", int'(mode_active), 0);
    vsync_n_in = 1'b0;
    step(1);
    chk("grey.commit", int'(mode_active), 2);
    vsync_n_in = 1'b1;
    r_in = 3'd7; g_in = 3'd0; b_in = 3'd0;
    step(2);
    chk_rgb("grey", 9, 9, 9);
    mode_sel = 2'd1;
    frame_start();
    chk("green.mode", int'(mode_active), 1);
    r_in = 3'd7; g_in = 3'd7; b_in = 3'd7;
    step(2);
    chk_rgb("green", 9, 63, 0);
    mode_sel = 2'd3;
    frame_start();
    step(2);
`ifdef MONITOR_FX_AMBER_EN
    chk("amber.mode", int'(mode_active), 3);
    chk_rgb("amber", 63, 27, 0);
`else
    chk("sel3.mode", int'(mode_active), 0);
    chk_rgb("sel3", 63, 63, 63);
`endif
    mode_sel = 2'd2;
    r_in = 3'd7; g_in = 3'd0; b_in = 3'd0;
    vsync_n_in = 1'b0;
    step(1);
    r_in = 3'd0;
    vsync_n_in = 1'b1;
    step(1);
    chk_rgb("commitpix", 9, 9, 9);
    mode_sel = 2'd0;
    frame_start();
    chk("cyc.base", int'(mode_active), 0);
    pulse();
    pulse();
    mode_sel = 2'd1;
    step(1);
    chk("cyc.midframe", int'(mode_active), 0);
    mode_sel = 2'd0;
    frame_start();
    chk("cyc.two", int'(mode_active), 2);
    for (int i = 0; i < NM - 2; i++) pulse();
    frame_start();
    chk("cyc.wrap", int'(mode_active), 0);
    for (int i = 0; i < NM; i++) pulse();
    frame_start();
    chk("cyc.full", int'(mode_active), 0);
    vsync_n_in = 1'b0;
    mode_cycle = 1'b1;
    step(1);
    chk("coinc.old", int'(mode_active), 0);
    vsync_n_in = 1'b1;
    mode_cycle = 1'b0;
    step(1);
    frame_start();
    chk("coinc.next", int'(mode_active), 1);
    r_in = 3'd7; g_in = 3'd7; b_in = 3'd7;
    step(2);
    chk_rgb("hold.pre", 9, 63, 0);
    ce_pix = 1'b0;
    r_in = 3'd0; g_in = 3'd0; b_in = 3'd0; blank_in = 1'b1; hsync_n_in = 1'b0;
    step(3);
    chk_rgb("hold", 9, 63, 0);
    chk("hold.bl", int'(blank_out), 0);
    chk("hold.hs", int'(hsync_n_out), 1);
    r_in = 3'd7; g_in = 3'd7; b_in = 3'd7;
    for (int i = 0; i < 3; i++) begin
      ce_pix = 1'b1;
      step(1);
      ce_pix = 1'b0;
      step(1);
    end
    chk_rgb("blank", 0, 0, 0);
    chk("blank.bl", int'(blank_out), 1);
    chk("blank.hs", int'(hsync_n_out), 0);
    ce_pix = 1'b1;
    blank_in = 1'b0;
    step(2);
    chk_rgb("prereset", 9, 63, 0);
    #2 reset_n = 1'b0;
    #1;
    chk_rgb("arst", 0, 0, 0);
    chk("arst.hs", int'(hsync_n_out), 1);
    chk("arst.vs", int'(vsync_n_out), 1);
    chk("arst.bl", int'(blank_out), 1);
    chk("arst.mode", int'(mode_active), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mode_sel = 2'd2;
    step(2);
    chk("postrst.mode", int'(mode_active), 0);
    chk_rgb("postrst", 63, 63, 63);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
